sub2_pipe: RTL and testbench

//  Pipelined WIDTH-bit parallel-prefix subtractor: diff = a_in - b_in, plus a borrow flag.

---
 rtl/sub2_pipe.sv | 111 +++++++++++
 tb/tb_sub2_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub2_pipe.sv
// Two-stage Kogge-Stone subtractor (diff = a - b, borrow = a < b) behind a valid/ready skid-free pipe.
// Latency 2 when unstalled, 1 result/cycle; define SUB2_SAT_EN to clamp diff to 0 on borrow.
module sub2_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LVLS = $clog2(WIDTH);

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             in_xfer;
  logic             s2_adv;
  logic [WIDTH-1:0] b_inv;

  logic [LVLS:0][WIDTH-1:0] pre_g;
  logic [LVLS:0][WIDTH-1:0] pre_p;
  logic [WIDTH-1:0]         carry;
  logic [WIDTH-1:0]         sum;
  logic                     cout;

  // Holding rst_n low also masks the handshakes so nothing moves on a reset edge.
  assign s2_adv    = s1_vld_q & (~s2_vld_q | out_ready);
  assign in_ready  = rst_n & (~s1_vld_q | s2_adv);
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = rst_n & s2_vld_q;
  assign b_inv     = ~b_in;

  always_comb begin
    s1_p_d   = s1_p_q;
    s1_g_d   = s1_g_q;
    s1_vld_d = in_xfer | (s1_vld_q & ~s2_adv);
    if (in_xfer) begin
      s1_p_d = a_in ^ b_inv;
      s1_g_d = a_in & b_inv;
      // Carry-in of 1 folded into bit 0: bit 0 generates whenever it propagates.
      s1_g_d[0] = (a_in[0] & b_inv[0]) | (a_in[0] ^ b_inv[0]);
    end
  end

  assign pre_g[0] = s1_g_q;
  assign pre_p[0] = s1_p_q;

  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_merge
        assign pre_g[k+1][i] = pre_g[k][i] | (pre_p[k][i] & pre_g[k][i-(1<<k)]);
        assign pre_p[k+1][i] = pre_p[k][i] & pre_p[k][i-(1<<k)];
      end else begin : g_pass
        assign pre_g[k+1][i] = pre_g[k][i];
        assign pre_p[k+1][i] = pre_p[k][i];
      end
    end
  end

  // Group generate (i:0) is the carry into bit i+1.
  assign carry = {pre_g[LVLS][WIDTH-2:0], 1'b1};
  assign sum   = s1_p_q ^ carry;
  assign cout  = pre_g[LVLS][WIDTH-1];

  always_comb begin
    diff_d   = diff_q;
    borrow_d = borrow_q;
    s2_vld_d = s2_adv | (s2_vld_q & ~out_ready);
    if (s2_adv) begin
      borrow_d = ~cout;
`ifdef SUB2_SAT_EN
      diff_d = cout ? sum : '0;
`else
      diff_d = sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_p_q   <= '0;
      s1_g_q   <= '0;
      s2_vld_q <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_p_q   <= s1_p_d;
      s1_g_q   <= s1_g_d;
      s2_vld_q <= s2_vld_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_sub2_pipe.sv
// Directed bench for sub2_pipe with an in-order scoreboard of {borrow, diff}.
module tb_sub2_pipe;

  localparam int W = 8;

`ifdef SUB2_SAT_EN
  localparam logic [W:0] E_UF   = 9'h100;  // 0x10 - 0x20
  localparam logic [W:0] E_0_FF = 9'h100;
  localparam logic [W:0] E_7F80 = 9'h100;
  localparam logic [W:0] E_0001 = 9'h100;
  localparam logic [W:0] E_1133 = 9'h100;
`else
  localparam logic [W:0] E_UF   = 9'h1F0;
  localparam logic [W:0] E_0_FF = 9'h101;
  localparam logic [W:0] E_7F80 = 9'h1FF;
  localparam logic [W:0] E_0001 = 9'h1FF;
  localparam logic [W:0] E_1133 = 9'h1DE;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_in, b_in;
  logic         in_valid, in_ready;
  logic [W-1:0] diff;
  logic         borrow, out_valid, out_ready;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   cur_exp;
  logic [W:0]   held;
  logic         acc;
  logic         stall_prev = 1'b0;

  logic [W-1:0] tab_a [8] = '{8'h5A, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'hC3};
  logic [W-1:0] tab_b [8] = '{8'h5A, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01, 8'hFE, 8'h3C};
  logic [W:0]   tab_e [8];

  sub2_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_in     (a_in),
    .b_in     (b_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .diff     (diff),
    .borrow   (borrow),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic         brw;
    logic [W-1:0] d;
    brw = (a < b);
    d   = a - b;
`ifdef SUB2_SAT_EN
    if (brw) d = '0;
`endif
    return {brw, d};
  endfunction

  // Observes the handshakes that the coming rising edge will act on.
  task automatic sample();
    logic [W:0] e;
    acc = 1'b0;
    if (!rst_n) begin
      stall_prev = 1'b0;
      return;
    end
    if (stall_prev) begin
      check_eq("hold_vld", out_valid, 1);
      check_eq("hold_dat", {borrow, diff}, held);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("result", {borrow, diff}, e);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      acc = 1'b1;
    end
    stall_prev = out_valid && !out_ready;
    held       = {borrow, diff};
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] e);
    a_in     = a;
    b_in     = b;
    cur_exp  = e;
    in_valid = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nacc;
    int guard;
    tab_e = '{9'h000, E_0_FF, 9'h0FF, 9'h001, E_7F80, E_0001, 9'h001, 9'h087};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cur_exp = '0;

    // Reset held for two edges.
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_in_rdy", in_ready, 0);
    check_eq("rst_out_vld", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_out_vld", out_valid, 0);
    check_eq("post_rst_in_rdy", in_ready, 1);
    check_eq("post_rst_dat", {borrow, diff}, 0);
    sample();
    @(posedge clk); #1;

    // Single op and latency.
    out_ready = 1'b1;
    drive(8'h5A, 8'h23, 9'h037);
    step();
    check_eq("t2_acc", acc, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_lat1", out_valid, 0);
    sample();
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t2_lat2", out_valid, 1);
    check_eq("t2_diff", diff, 8'h37);
    check_eq("t2_borrow", borrow, 0);
    sample();
    @(posedge clk); #1;

    // Underflow.
    drive(8'h10, 8'h20, E_UF);
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check_eq("t3_vld", out_valid, 1);
    check_eq("t3_dat", {borrow, diff}, E_UF);
    sample();
    @(posedge clk); #1;

    // Boundary table then 256 random pairs, random out_ready.
    for (int i = 0; i < 8 + 256; i++) begin
      if (i < 8) drive(tab_a[i], tab_b[i], tab_e[i]);
      else begin
        a_in = W'($urandom);
        b_in = W'($urandom);
        drive(a_in, b_in, model(a_in, b_in));
      end
      guard = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        guard++;
      end while (!acc && guard < 40);
      if (!acc) check_eq("stream_accept", acc, 1);
      in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    out_ready = 1'b1;
    drain(50);

    // Backpressure: only two ops fit.
    out_ready = 1'b0;
    nacc = 0;
    repeat (4) begin
      if (nacc == 0) drive(8'h33, 8'h11, 9'h022);
      else           drive(8'h11, 8'h33, E_1133);
      step();
      if (acc) nacc++;
    end
    check_eq("bp_acc_cnt", nacc, 2);
    @(negedge clk);
    check_eq("bp_in_rdy", in_ready, 0);
    sample();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rdy_release", in_ready, 1);
    sample();
    @(posedge clk); #1;
    drain(10);

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(8'h12, 8'h34, model(8'h12, 8'h34));
    step();
    drive(8'h56, 8'h78, model(8'h56, 8'h78));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_full", out_valid, 1);
    sample();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_out_vld", out_valid, 0);
    check_eq("t6_rst_in_rdy", in_ready, 0);
    sample();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("t6_post_out_vld", out_valid, 0);
    sample();
    @(posedge clk); #1;
    drive(8'hFF, 8'hFF, 9'h000);
    step();
    check_eq("t6_acc", acc, 1);
    in_valid = 1'b0;
    drain(10);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
